// File: rtl/s27_pkg.sv
// Shared widths, state bit indices and the combinational s27 lane function.
package s27_pkg;

  localparam int S27_STATE_W = 3;
  localparam int G5 = 0;
  localparam int G6 = 1;
  localparam int G7 = 2;

  // Returns {next_state[G7:G5], g17c} for one lane.
  function automatic logic [S27_STATE_W:0] s27_next(
    input logic [S27_STATE_W-1:0] state,
    input logic                   g0,
    input logic                   g1,
    input logic                   g2,
    input logic                   g3
  );
    logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = ~g0;
    g8  = g14 & state[G6];
    g12 = ~(g1 | state[G7]);
    g15 = g12 | g8;
    g16 = g3 | g8;
    g9  = ~(g16 & g15);
    g11 = ~(state[G5] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(g2 | g12);
    return {g13, g11, g10, ~g11};
  endfunction

endpackage

// File: rtl/s27_lane.sv
// One s27 lane: 3-bit state register with scan/hold/update mux and its
// combinational next-state and G17 logic.
module s27_lane
  import s27_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   se,
  input  logic                   scan_in,
  input  logic                   g0,
  input  logic                   g1,
  input  logic                   g2,
  input  logic                   g3,
  output logic [S27_STATE_W-1:0] state,
  output logic                   g17c,
  output logic                   scan_out
);

  logic [S27_STATE_W-1:0] state_q, state_d, next_state;

  always_comb begin
    {next_state, g17c} = s27_next(state_q, g0, g1, g2, g3);
    state_d = state_q;
    // Scan has priority over the functional enable; chain runs G5 -> G6 -> G7.
    if (se) begin
      state_d = {state_q[S27_STATE_W-2:0], scan_in};
    end else if (en) begin
      state_d = next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state    = state_q;
  assign scan_out = state_q[G7];

endmodule

// File: rtl/s27_array.sv
// LANES independent s27 lanes with input path-balancing DFFs, optional
// registered G17 and a full-state scan chain (lane0.G5 first, lane(N-1).G7 = SO).
module s27_array
  import s27_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int BAL_DEPTH = 2,
  parameter int OUT_REG   = 1
) (
  input  logic                     CK,
  input  logic                     RN,
  input  logic [LANES-1:0]         G0,
  input  logic [LANES-1:0]         G1,
  input  logic [LANES-1:0]         G2,
  input  logic [LANES-1:0]         G3,
  input  logic                     EN,
  input  logic                     SE,
  input  logic                     SI,
  output logic                     SO,
  output logic [LANES-1:0]         G17,
  output logic [3*LANES-1:0]       ST
);

  logic [4*LANES-1:0] raw_in, bal_in;
  logic [LANES:0]     chain;
  logic [LANES-1:0]   g17c;

  assign raw_in = {G3, G2, G1, G0};

  generate
    if (BAL_DEPTH == 0) begin : g_nobal
      assign bal_in = raw_in;
    end else begin : g_bal
      logic [4*LANES-1:0] bal_q [BAL_DEPTH];
      logic [4*LANES-1:0] bal_d [BAL_DEPTH];

      // Free-running delay line: shifts regardless of EN and SE.
      always_comb begin
        bal_d[0] = raw_in;
        for (int k = 1; k < BAL_DEPTH; k++) begin
          bal_d[k] = bal_q[k-1];
        end
      end

      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          for (int k = 0; k < BAL_DEPTH; k++) begin
            bal_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < BAL_DEPTH; k++) begin
            bal_q[k] <= bal_d[k];
          end
        end
      end

      assign bal_in = bal_q[BAL_DEPTH-1];
    end
  endgenerate

  assign chain[0] = SI;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      s27_lane u_lane (
        .clk      (CK),
        .rst_n    (RN),
        .en       (EN),
        .se       (SE),
        .scan_in  (chain[i]),
        .g0       (bal_in[i]),
        .g1       (bal_in[LANES+i]),
        .g2       (bal_in[2*LANES+i]),
        .g3       (bal_in[3*LANES+i]),
        .state    (ST[S27_STATE_W*i +: S27_STATE_W]),
        .g17c     (g17c[i]),
        .scan_out (chain[i+1])
      );
    end
  endgenerate

  assign SO = chain[LANES];

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [LANES-1:0] g17_q, g17_d;

      // Samples every cycle, including scan and hold.
      always_comb begin
        g17_d = g17c;
      end

      always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
          g17_q <= '0;
        end else begin
          g17_q <= g17_d;
        end
      end

      assign G17 = g17_q;
    end else begin : g_ocomb
      assign G17 = g17c;
    end
  endgenerate

endmodule

// File: tb/tb_s27_array.sv
// Scoreboard bench for two s27_array configurations sharing one stimulus stream.
module tb_s27_array;

  localparam int L = 4;
  localparam int W = 3 * L;

  logic         CK = 1'b0;
  logic         RN = 1'b0;
  logic [L-1:0] G0 = '0, G1 = '0, G2 = '0, G3 = '0;
  logic         EN = 1'b0, SE = 1'b0, SI = 1'b0;

  logic         so_a, so_b;
  logic [L-1:0] g17_a, g17_b;
  logic [W-1:0] st_a, st_b;

  always #5 CK = ~CK;

  s27_array #(.LANES(L), .BAL_DEPTH(2), .OUT_REG(1)) dut_a (
    .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .EN(EN), .SE(SE), .SI(SI), .SO(so_a), .G17(g17_a), .ST(st_a)
  );

  s27_array #(.LANES(L), .BAL_DEPTH(0), .OUT_REG(0)) dut_b (
    .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .EN(EN), .SE(SE), .SI(SI), .SO(so_b), .G17(g17_b), .ST(st_b)
  );

  typedef struct packed {
    logic [L-1:0] g0;
    logic [L-1:0] g1;
    logic [L-1:0] g2;
    logic [L-1:0] g3;
  } in_t;

  typedef struct packed {
    logic [W-1:0] st_a;
    logic [L-1:0] g17_a;
    logic         so_a;
    logic [W-1:0] st_b;
    logic [L-1:0] g17_b;
    logic         so_b;
  } exp_t;

  exp_t         exp_q[$];
  in_t          hist_a[$];
  logic [W-1:0] m_st_a, m_st_b;
  int           n_checks = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the s27 equations applied to every lane of a flat state vector.
  task automatic lanes_eval(input logic [W-1:0] st, input in_t in,
                            output logic [W-1:0] nst, output logic [L-1:0] g17c);
    for (int i = 0; i < L; i++) begin
      logic s5, s6, s7, a14, a8, a12, a15, a16, a9, a11, a10, a13;
      s5 = st[3*i]; s6 = st[3*i+1]; s7 = st[3*i+2];
      a14 = ~in.g0[i];
      a8  = a14 & s6;
      a12 = ~(in.g1[i] | s7);
      a15 = a12 | a8;
      a16 = in.g3[i] | a8;
      a9  = ~(a16 & a15);
      a11 = ~(s5 | a9);
      a10 = ~(a14 | a11);
      a13 = ~(in.g2[i] | a12);
      nst[3*i]   = a10;
      nst[3*i+1] = a11;
      nst[3*i+2] = a13;
      g17c[i]    = ~a11;
    end
  endtask

  // Drive one cycle's inputs now and predict outputs seen just after the next rising edge.
  task automatic apply(input in_t in, input logic en, input logic se, input logic si);
    logic [W-1:0] nxt;
    logic [L-1:0] gc;
    in_t          bal;
    exp_t         e;
    G0 = in.g0; G1 = in.g1; G2 = in.g2; G3 = in.g3;
    EN = en; SE = se; SI = si;

    bal = hist_a[0];
    lanes_eval(m_st_a, bal, nxt, gc);
    e.g17_a = gc;
    if (se)      m_st_a = {m_st_a[W-2:0], si};
    else if (en) m_st_a = nxt;
    hist_a.delete(0);
    hist_a.push_back(in);

    lanes_eval(m_st_b, in, nxt, gc);
    if (se)      m_st_b = {m_st_b[W-2:0], si};
    else if (en) m_st_b = nxt;
    lanes_eval(m_st_b, in, nxt, gc);
    e.g17_b = gc;

    e.st_a = m_st_a; e.so_a = m_st_a[W-1];
    e.st_b = m_st_b; e.so_b = m_st_b[W-1];
    exp_q.push_back(e);
  endtask

  task automatic step(input in_t in, input logic en, input logic se, input logic si);
    @(negedge CK);
    apply(in, en, se, si);
  endtask

  function automatic in_t rand_in();
    logic [31:0] rv;
    rv = $urandom;
    return rv[15:0];
  endfunction

  task automatic do_reset();
    @(negedge CK);
    #2;
    G0 = '0; G1 = '0; G2 = '0; G3 = '0; EN = 1'b0; SE = 1'b0; SI = 1'b0;
    RN = 1'b0;
    #1;
    chk("rst_st_a", st_a, 0);
    chk("rst_so_a", so_a, 0);
    chk("rst_g17_a", g17_a, 0);
    chk("rst_st_b", st_b, 0);
    chk("rst_so_b", so_b, 0);
    chk("rst_g17_b", g17_b, 4'hF);
    repeat (2) @(posedge CK);
    #1;
    chk("rst_hold_st_a", st_a, 0);
    @(negedge CK);
    RN = 1'b1;
    m_st_a = '0;
    m_st_b = '0;
    hist_a.delete();
    repeat (2) hist_a.push_back('0);
    apply('0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge CK) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("st_a", st_a, e.st_a);
      chk("g17_a", g17_a, e.g17_a);
      chk("so_a", so_a, e.so_a);
      chk("st_b", st_b, e.st_b);
      chk("g17_b", g17_b, e.g17_b);
      chk("so_b", so_b, e.so_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    in_t          inp;

    do_reset();

    // Single functional steps: G0=G3=1 from reset, then G0=0, G3=1, then hold.
    inp = '0; inp.g0 = '1; inp.g3 = '1;
    step(inp, 1'b1, 1'b0, 1'b0);
    inp.g0 = '0;
    repeat (3) step(inp, 1'b1, 1'b0, 1'b0);
    repeat (3) step(rand_in(), 1'b0, 1'b0, 1'b0);
    repeat (4) step(inp, 1'b1, 1'b0, 1'b0);

    // Full scan load with EN also high: only the shift must happen.
    pat = 12'b1011_0010_1101;
    for (int k = W - 1; k >= 0; k--) step(rand_in(), 1'b1, 1'b1, pat[k]);
    repeat (3) step(rand_in(), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < W; k++) step(rand_in(), 1'b0, 1'b1, 1'b0);

    // Reset after a partial scan, then reload from an empty chain.
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b1, 1'b1);
    do_reset();
    for (int k = 0; k < W; k++) step(rand_in(), 1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        do_reset();
      end else begin
        step(rand_in(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    for (int k = 0; k < W; k++) step(rand_in(), 1'b1, 1'b1, 1'b0);

    repeat (3) @(negedge CK);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
